vga_sync_gen: RTL and testbench

Generates 640x480@60 Hz VGA timing from the system clock. It produces the pixel_x, pixel_y and video_on signals that drive the pixel/colour generator, plus hsync and vsync for the connector. It also provides pixel, line and frame strobes for the game logic, which moves player and enemy positions once per frame. Timing is counter-based throughout, using a pixel clock-enable rather than a derived clock.

---
 rtl/vga_timing_pkg.sv | 27 ++
 rtl/vga_sync_gen_if.sv | 21 ++
 rtl/vga_sync_gen_tick.sv | 29 ++
 rtl/vga_sync_gen.sv | 86 ++++++++
 tb/tb_vga_sync_gen.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// 640x480@60 Hz timing constants shared by the sync generator and the pixel generator.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int unsigned H_DISPLAY = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned V_DISPLAY = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;

  localparam int unsigned H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int unsigned V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  function automatic logic in_display(coord_t x, coord_t y);
    return (int'(x) < H_DISPLAY) && (int'(y) < V_DISPLAY);
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Timing bundle from the sync generator to the pixel generator and game logic.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic   p_tick;
  coord_t pixel_x;
  coord_t pixel_y;
  logic   video_on;
  logic   hsync;
  logic   vsync;
  logic   line_tick;
  logic   frame_tick;

  modport master (
    output p_tick, pixel_x, pixel_y, video_on, hsync, vsync, line_tick, frame_tick
  );

  modport slave (
    input p_tick, pixel_x, pixel_y, video_on, hsync, vsync, line_tick, frame_tick
  );
endinterface

// File: rtl/vga_sync_gen_tick.sv
// Pixel clock-enable divider: registered one-cycle p_tick every CLK_DIV clk_d edges.
module pixel_tick_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_d,
  input  logic reset,
  output logic p_tick,
  output logic p_tick_pre
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;

  // p_tick_pre is the value p_tick takes after the coming edge.
  assign p_tick_pre = (div_cnt == LAST);

  always_ff @(posedge clk_d or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      p_tick  <= 1'b0;
    end else begin
      p_tick  <= p_tick_pre;
      div_cnt <= p_tick_pre ? '0 : div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: pixel/line counters with registered sync, blanking and strobes.
module vga_sync_gen #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned H_DISPLAY   = vga_timing_pkg::H_DISPLAY,
  parameter int unsigned H_FRONT     = vga_timing_pkg::H_FRONT,
  parameter int unsigned H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BACK      = vga_timing_pkg::H_BACK,
  parameter int unsigned V_DISPLAY   = vga_timing_pkg::V_DISPLAY,
  parameter int unsigned V_FRONT     = vga_timing_pkg::V_FRONT,
  parameter int unsigned V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BACK      = vga_timing_pkg::V_BACK,
  parameter logic        SYNC_ACTIVE = 1'b0
) (
  input  logic           clk_d,
  input  logic           reset,
  vga_sync_gen_if.master sync
);
  import vga_timing_pkg::*;

  localparam int unsigned HT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_LAST   = coord_t'(HT - 1);
  localparam coord_t V_LAST   = coord_t'(VT - 1);
  localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
  localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
  localparam coord_t HS_FIRST = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HS_LAST  = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_FIRST = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VS_LAST  = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic   p_tick, p_tick_pre;
  coord_t h_cnt, v_cnt, h_next, v_next;
  logic   h_wrap;
  logic   video_on, hsync, vsync, line_tick, frame_tick;

  pixel_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk_d      (clk_d),
    .reset      (reset),
    .p_tick     (p_tick),
    .p_tick_pre (p_tick_pre)
  );

  always_comb begin
    h_wrap = p_tick && (h_cnt == H_LAST);
    h_next = h_cnt;
    v_next = v_cnt;
    if (p_tick) begin
      h_next = h_wrap ? '0 : h_cnt + coord_t'(1);
    end
    if (h_wrap) begin
      v_next = (v_cnt == V_LAST) ? '0 : v_cnt + coord_t'(1);
    end
  end

  // Decodes use next-state counters so every output moves on the same edge as pixel_x/pixel_y.
  always_ff @(posedge clk_d or posedge reset) begin
    if (reset) begin
      h_cnt      <= '0;
      v_cnt      <= '0;
      video_on   <= 1'b1;
      hsync      <= ~SYNC_ACTIVE;
      vsync      <= ~SYNC_ACTIVE;
      line_tick  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      h_cnt      <= h_next;
      v_cnt      <= v_next;
      video_on   <= (h_next < H_VIS) && (v_next < V_VIS);
      hsync      <= ((h_next >= HS_FIRST) && (h_next <= HS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync      <= ((v_next >= VS_FIRST) && (v_next <= VS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      line_tick  <= p_tick_pre && (h_next == H_LAST);
      frame_tick <= p_tick_pre && (h_next == H_LAST) && (v_next == V_LAST);
    end
  end

  assign sync.p_tick     = p_tick;
  assign sync.pixel_x    = h_cnt;
  assign sync.pixel_y    = v_cnt;
  assign sync.video_on   = video_on;
  assign sync.hsync      = hsync;
  assign sync.vsync      = vsync;
  assign sync.line_tick  = line_tick;
  assign sync.frame_tick = frame_tick;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench: full-size 640x480 generator (CLK_DIV=4) plus a shrunken CLK_DIV=1 active-high-sync instance.
module tb_vga_sync_gen;

  typedef struct packed {
    logic       p;
    logic [9:0] x;
    logic [9:0] y;
    logic       v;
    logic       hs;
    logic       vs;
    logic       lt;
    logic       ft;
  } exp_t;

  typedef struct {
    int   n;
    exp_t e;
  } vec_t;

  logic clk_d = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  always #5 clk_d = ~clk_d;

  vga_sync_gen_if ifa ();
  vga_sync_gen_if ifb ();

  vga_sync_gen #(.CLK_DIV(4)) dut_a (
    .clk_d (clk_d),
    .reset (rst_a),
    .sync  (ifa)
  );

  // Small geometry: HT=24 (sync 18..20), VT=12 (sync 8..9), frame = 288 pixels.
  vga_sync_gen #(
    .CLK_DIV(1), .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .SYNC_ACTIVE(1'b1)
  ) dut_b (
    .clk_d (clk_d),
    .reset (rst_b),
    .sync  (ifb)
  );

  int   n_vec = 0;
  int   n_err = 0;
  int   n_a = 0;
  int   n_b = 0;
  bit   sb_a_on = 0;
  bit   sb_b_on = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t qt[$];

  function automatic exp_t mk(bit p, int x, int y, bit v, bit hs, bit vs, bit lt, bit ft);
    mk = {p, 10'(x), 10'(y), v, hs, vs, lt, ft};
  endfunction

  // Closed-form reference: output state after n clk_d edges since reset release.
  function automatic exp_t model(int n, int d, int ht, int vt, int hd, int vd,
                                 int hs0, int hs1, int vs0, int vs1, bit act);
    int   pidx, px, py;
    exp_t e;
    pidx = (n >= 1) ? (n - 1) / d : 0;
    px   = pidx % ht;
    py   = (pidx / ht) % vt;
    e.p  = (n >= d) && (n % d == 0);
    e.x  = 10'(px);
    e.y  = 10'(py);
    e.v  = (px < hd) && (py < vd);
    e.hs = (px >= hs0 && px <= hs1) ? act : !act;
    e.vs = (py >= vs0 && py <= vs1) ? act : !act;
    e.lt = e.p && (px == ht - 1);
    e.ft = e.lt && (py == vt - 1);
    return e;
  endfunction

  function automatic exp_t samp_a();
    return {ifa.p_tick, ifa.pixel_x, ifa.pixel_y, ifa.video_on, ifa.hsync, ifa.vsync,
            ifa.line_tick, ifa.frame_tick};
  endfunction

  function automatic exp_t samp_b();
    return {ifb.p_tick, ifb.pixel_x, ifb.pixel_y, ifb.video_on, ifb.hsync, ifb.vsync,
            ifb.line_tick, ifb.frame_tick};
  endfunction

  task automatic check(string name, exp_t got, exp_t want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got p=%b x=%0d y=%0d v=%b hs=%b vs=%b lt=%b ft=%b, want p=%b x=%0d y=%0d v=%b hs=%b vs=%b lt=%b ft=%b",
               name, got.p, got.x, got.y, got.v, got.hs, got.vs, got.lt, got.ft,
               want.p, want.x, want.y, want.v, want.hs, want.vs, want.lt, want.ft);
    end
  endtask

  task automatic check_int(string name, int got, int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Producers: push the expected state for each edge as it is applied.
  always @(posedge clk_d) begin
    if (rst_a) n_a = 0;
    else begin
      n_a++;
      if (sb_a_on) qa.push_back(model(n_a, 4, 800, 525, 640, 480, 656, 751, 490, 491, 1'b0));
    end
    if (rst_b) n_b = 0;
    else begin
      n_b++;
      if (sb_b_on) qb.push_back(model(n_b, 1, 24, 12, 16, 6, 18, 20, 8, 9, 1'b1));
    end
  end

  int a_hs_lo = 0, a_lt = 0, a_vid = 0;
  bit a_cnt_en = 1;
  int b_last_ft = 0, b_vs = 0, b_vid = 0, b_ft_n = 0;

  // Consumers: pop and compare mid-cycle.
  always @(negedge clk_d) begin
    exp_t w;
    if (sb_a_on && qa.size() > 0) begin
      w = qa.pop_front();
      check("a_sb", samp_a(), w);
      if (a_cnt_en && n_a <= 3200) begin
        if (!ifa.hsync) a_hs_lo++;
        if (ifa.line_tick) a_lt++;
        if (ifa.p_tick && ifa.video_on) a_vid++;
      end
    end
    if (sb_b_on && qb.size() > 0) begin
      w = qb.pop_front();
      check("b_sb", samp_b(), w);
      if (ifb.vsync) b_vs++;
      if (ifb.p_tick && ifb.video_on) b_vid++;
      if (ifb.frame_tick) begin
        check_int("b_frame_period", n_b - b_last_ft, 288);
        check_int("b_vsync_pixels", b_vs, 48);
        check_int("b_video_pixels", b_vid, 96);
        b_last_ft = n_b;
        b_vs      = 0;
        b_vid     = 0;
        b_ft_n++;
      end
    end
  end

  vec_t tab[15];

  initial begin
    tab[0]  = '{0,    mk(0, 0,   0, 1, 1, 1, 0, 0)};
    tab[1]  = '{3,    mk(0, 0,   0, 1, 1, 1, 0, 0)};
    tab[2]  = '{4,    mk(1, 0,   0, 1, 1, 1, 0, 0)};
    tab[3]  = '{5,    mk(0, 1,   0, 1, 1, 1, 0, 0)};
    tab[4]  = '{8,    mk(1, 1,   0, 1, 1, 1, 0, 0)};
    tab[5]  = '{9,    mk(0, 2,   0, 1, 1, 1, 0, 0)};
    tab[6]  = '{2560, mk(1, 639, 0, 1, 1, 1, 0, 0)};
    tab[7]  = '{2561, mk(0, 640, 0, 0, 1, 1, 0, 0)};
    tab[8]  = '{2624, mk(1, 655, 0, 0, 1, 1, 0, 0)};
    tab[9]  = '{2625, mk(0, 656, 0, 0, 0, 1, 0, 0)};
    tab[10] = '{3008, mk(1, 751, 0, 0, 0, 1, 0, 0)};
    tab[11] = '{3009, mk(0, 752, 0, 0, 1, 1, 0, 0)};
    tab[12] = '{3200, mk(1, 799, 0, 0, 1, 1, 1, 0)};
    tab[13] = '{3201, mk(0, 0,   1, 1, 1, 1, 0, 0)};
    tab[14] = '{3204, mk(1, 0,   1, 1, 1, 1, 0, 0)};

    repeat (3) @(negedge clk_d);
    #1;
    check("a_reset_hold", samp_a(), mk(0, 0, 0, 1, 1, 1, 0, 0));
    check("b_reset_hold", samp_b(), mk(0, 0, 0, 1, 0, 0, 0, 0));
    @(negedge clk_d);
    rst_a = 0; rst_b = 0; sb_a_on = 1; sb_b_on = 1;

    for (int i = 0; i < 15; i++) begin
      while (n_a < tab[i].n) @(negedge clk_d);
      qt.push_back(tab[i].e);
      check($sformatf("a_vec%0d_n%0d", i, tab[i].n), samp_a(), qt.pop_front());
    end
    check_int("a_hsync_low_clks", a_hs_lo, 384);
    check_int("a_line_ticks", a_lt, 1);
    check_int("a_video_pixels", a_vid, 640);
    a_cnt_en = 0;

    // Asynchronous reset at (700,1) while hsync is asserted.
    while (n_a != 6002) @(negedge clk_d);
    check("a_pre_rst", samp_a(), mk(0, 700, 1, 0, 0, 1, 0, 0));
    #2; sb_a_on = 0; rst_a = 1;
    #1;
    check("a_async_rst", samp_a(), mk(0, 0, 0, 1, 1, 1, 0, 0));
    qa.delete();
    @(negedge clk_d);
    rst_a = 0; sb_a_on = 1;
    while (n_a < 3) @(negedge clk_d);
    check("a_rel_n3", samp_a(), mk(0, 0, 0, 1, 1, 1, 0, 0));
    @(negedge clk_d);
    check("a_rel_n4", samp_a(), mk(1, 0, 0, 1, 1, 1, 0, 0));

    // Asynchronous reset at (20,9) while both syncs are asserted.
    while (n_b < 288 || ((n_b - 1) % 288) != 236) @(negedge clk_d);
    check("b_pre_rst", samp_b(), mk(1, 20, 9, 0, 1, 1, 0, 0));
    #2; sb_b_on = 0; rst_b = 1;
    #1;
    check("b_async_rst", samp_b(), mk(0, 0, 0, 1, 0, 0, 0, 0));
    qb.delete();
    b_last_ft = 0; b_vs = 0; b_vid = 0; b_ft_n = 0;
    @(negedge clk_d);
    rst_b = 0; sb_b_on = 1;
    while (n_b < 600) @(negedge clk_d);
    check_int("b_frames_after_rst", b_ft_n, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1);
  end

endmodule
